dmi_jtag_ctrl: RTL and testbench
================================

# dmi_jtag_ctrl

Sequencer for the DMI access data register of the RISC-V debug transport module. It sits behind the JTAG TAP controller in the TCK domain and owns the 41-bit DMI shift register. On Update-DR it turns a shifted request into a valid/ready transaction to the debug module, then collects the response for the next Capture-DR. It also tracks the sticky DMI error status that the TAP reports through the dtmcs `dmistat` field.

## Interface
- AddrWidth, 7, DMI address width; DR length = AddrWidth+34 (41 by default)
- tck_i  in  1  JTAG test clock; all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- dmi_access_i  in  1  TAP IR selects DMIACCESS
- capture_dr_i  in  1  TAP in Capture-DR
- shift_dr_i  in  1  TAP in Shift-DR
- update_dr_i  in  1  TAP in Update-DR
- dmi_reset_i  in  1  dtmcs.dmireset strobe; clears sticky error
- tdi_i  in  1  serial data in
- tdo_o  out  1  serial data out, = dr_q[0]
- dmi_error_o  out  2  sticky error to dtmcs.dmistat: 0 ok, 2 op failed, 3 busy
- dmi_req_valid_o  out  1  request valid
- dmi_req_ready_i  in  1  request accepted
- dmi_req_op_o  out  2  1 read, 2 write
- dmi_req_addr_o  out  AddrWidth  request address
- dmi_req_data_o  out  32  write data
- dmi_resp_valid_i  in  1  response valid
- dmi_resp_ready_o  out  1  response accepted
- dmi_resp_data_i  in  32  read data
- dmi_resp_resp_i  in  2  0 success, nonzero failure

## Operation
- DR layout: dr_q = {addr[AddrWidth-1:0], data[31:0], op[1:0]}; op occupies the LSBs.
- Holding regs: addr_q, data_q, error_q. State machine: Idle, Read, WaitRead, Write, WaitWrite.
- Capture (capture_dr_i & dmi_access_i):
  - If state != Idle, error_q <= 3 first.
  - dr_q <= {addr_q, data_q, new error_q}.
- Shift (shift_dr_i & dmi_access_i): dr_q <= {tdi_i, dr_q[40:1]}.
- Update (update_dr_i & dmi_access_i):
  - If error_q != 0: ignore.
  - Else if state != Idle: error_q <= 3, no request.
  - Else addr_q <= dr_q addr field and data_q <= dr_q data field, then:
    - op=1 → Read
    - op=2 → Write
    - op=0 or 3 → stay Idle; addr_q and data_q are still loaded.
- Read/Write states:
  - dmi_req_valid_o=1; op, addr_q and data_q are driven.
  - On dmi_req_ready_i, go to WaitRead/WaitWrite.
- WaitRead/WaitWrite states:
  - dmi_resp_ready_o=1.
  - On dmi_resp_valid_i:
    - WaitRead: data_q <= dmi_resp_data_i.
    - If dmi_resp_resp_i != 0 and error_q == 0: error_q <= 2.
    - Go to Idle.
- dmi_resp_ready_o=0 outside Wait states; a response arriving there is not consumed.
- dmi_reset_i clears error_q to 0. It has priority over a same-cycle busy or fail set. It does not abort an in-flight transaction.
- dmi_access_i low: capture, shift and update are ignored; the in-flight transaction continues.

## Timing
- Reset values (rst_i high at a tck_i edge): state Idle, dr_q/addr_q/data_q/error_q = 0. So tdo_o=0, dmi_error_o=0, dmi_req_valid_o=0, dmi_resp_ready_o=0, and request fields are 0.
- Reset mid-transaction drops the request immediately. No response is awaited afterwards.
- dmi_req_valid_o rises the edge after update_dr_i, i.e. 1-cycle latency. It is held stable, with fields unchanged, until the cycle dmi_req_ready_i=1.
- req_valid and resp_ready are decoded from state only; there is no combinational path from ready/valid inputs to outputs.
- Response is consumed in the cycle valid&ready. State is Idle from the next edge; the earliest capture that sees the data is that cycle.
- Minimal idle-free transaction (ready and resp both immediate): update at cycle N, req at N+1, resp consumed at N+2, Idle at N+3.
- tdo_o is combinational from dr_q[0]; the TAP retimes it on the falling edge.
- Simultaneous capture and dmi_reset_i: error cleared, captured op field = 0 unless busy sets it in the same cycle. Reset wins, so op field = 0.

## Test plan
- Write: shift op=2, addr=0x10, data=0xDEADBEEF; update → req_valid next cycle with op=2, addr=0x10, data=0xDEADBEEF. Hold ready low 3 cycles: fields stable. Resp resp=0 → Idle, dmi_error_o=0.
- Read: op=1, addr=0x11; resp data=0x12345678, resp=0 → next capture shifts out op=0, data=0x12345678, addr=0x11, LSB first on tdo_o.
- Busy: update a read, withhold ready; capture → captured op=3, dmi_error_o=3. Further update is ignored, no new request. Pulse dmi_reset_i → dmi_error_o=0.
- Failure: write response resp=2 → dmi_error_o=2. Next update with op=1 → no request. dmi_reset_i then op=1 → request issued.
- Nop/reserved: update op=0 and op=3 → no req_valid; addr_q/data_q loaded and visible on next capture.
- Reset: rst_i while in WaitRead → req_valid=0, resp_ready=0, dmi_error_o=0, capture yields all zeros.

Source files
------------

// File: rtl/dmi_jtag_ctrl.sv
// rtl/dmi_jtag_ctrl.sv - DMI access data register sequencer in the TCK domain
module dmi_jtag_ctrl #(
  parameter int unsigned AddrWidth = 7
) (
  input  logic                 tck_i,
  input  logic                 rst_i,
  input  logic                 dmi_access_i,
  input  logic                 capture_dr_i,
  input  logic                 shift_dr_i,
  input  logic                 update_dr_i,
  input  logic                 dmi_reset_i,
  input  logic                 tdi_i,
  output logic                 tdo_o,
  output logic [1:0]           dmi_error_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [1:0]           dmi_req_op_o,
  output logic [AddrWidth-1:0] dmi_req_addr_o,
  output logic [31:0]          dmi_req_data_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic [1:0]           dmi_resp_resp_i
);

  localparam int unsigned DrWidth = AddrWidth + 34;

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;
  localparam logic [1:0] ErrFail = 2'd2;
  localparam logic [1:0] ErrBusy = 2'd3;

  typedef enum logic [2:0] {
    Idle,
    Read,
    WaitRead,
    Write,
    WaitWrite
  } state_e;

  state_e                 state_q;
  logic [DrWidth-1:0]     dr_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [31:0]            data_q;
  logic [1:0]             error_q;

  logic                   capture;
  logic                   shift;
  logic                   update;
  logic                   is_idle;
  logic                   in_wait;
  logic                   resp_fire;
  logic                   set_busy;
  logic                   set_fail;
  logic                   req_accept;
  logic [1:0]             error_d;

  // Decode TAP strobes and work out the sticky error for this cycle
  always_comb begin
    capture    = capture_dr_i & dmi_access_i;
    shift      = shift_dr_i & dmi_access_i;
    update     = update_dr_i & dmi_access_i;
    is_idle    = (state_q == Idle);
    in_wait    = (state_q == WaitRead) || (state_q == WaitWrite);
    resp_fire  = in_wait & dmi_resp_valid_i;
    // Capture while busy reports busy; an update while busy only counts if no error is latched yet
    set_busy   = ~is_idle & (capture | (update & (error_q == 2'd0)));
    set_fail   = resp_fire & (dmi_resp_resp_i != 2'd0) & (error_q == 2'd0);
    req_accept = update & (error_q == 2'd0) & is_idle;
    error_d    = error_q;
    // dmireset beats any same-cycle set; busy is reported in preference to fail
    if (dmi_reset_i) begin
      error_d = 2'd0;
    end else if (set_busy) begin
      error_d = ErrBusy;
    end else if (set_fail) begin
      error_d = ErrFail;
    end
  end

  // Shift register, holding registers and transaction sequencer
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      state_q <= Idle;
      dr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= 2'd0;
    end else begin
      error_q <= error_d;

      if (capture) begin
        dr_q <= {addr_q, data_q, error_d};
      end else if (shift) begin
        dr_q <= {tdi_i, dr_q[DrWidth-1:1]};
      end

      if (req_accept) begin
        addr_q <= dr_q[DrWidth-1 -: AddrWidth];
        data_q <= dr_q[33:2];
      end

      case (state_q)
        Idle: begin
          if (req_accept) begin
            case (dr_q[1:0])
              OpRead:  state_q <= Read;
              OpWrite: state_q <= Write;
              default: state_q <= Idle;
            endcase
          end
        end
        Read: begin
          if (dmi_req_ready_i) state_q <= WaitRead;
        end
        Write: begin
          if (dmi_req_ready_i) state_q <= WaitWrite;
        end
        WaitRead: begin
          if (dmi_resp_valid_i) begin
            data_q  <= dmi_resp_data_i;
            state_q <= Idle;
          end
        end
        WaitWrite: begin
          if (dmi_resp_valid_i) state_q <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign tdo_o            = dr_q[0];
  assign dmi_error_o      = error_q;
  assign dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
  assign dmi_req_op_o     = (state_q == Read)  ? OpRead  :
                            (state_q == Write) ? OpWrite : 2'd0;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_data_o   = data_q;
  assign dmi_resp_ready_o = in_wait;

endmodule

// File: tb/tb_dmi_jtag_ctrl.sv
// tb/tb_dmi_jtag_ctrl.sv - self-checking bench for dmi_jtag_ctrl
module tb_dmi_jtag_ctrl;

  logic        tck = 1'b0;
  logic        rst = 1'b1;
  logic        access = 1'b0;
  logic        capture = 1'b0;
  logic        shift = 1'b0;
  logic        update = 1'b0;
  logic        dmi_reset = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic [1:0]  err;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [1:0]  req_op;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [31:0] resp_data = 32'd0;
  logic [1:0]  resp_resp = 2'd0;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  dmi_jtag_ctrl #(.AddrWidth(7)) dut (
    .tck_i(tck),
    .rst_i(rst),
    .dmi_access_i(access),
    .capture_dr_i(capture),
    .shift_dr_i(shift),
    .update_dr_i(update),
    .dmi_reset_i(dmi_reset),
    .tdi_i(tdi),
    .tdo_o(tdo),
    .dmi_error_o(err),
    .dmi_req_valid_o(req_valid),
    .dmi_req_ready_i(req_ready),
    .dmi_req_op_o(req_op),
    .dmi_req_addr_o(req_addr),
    .dmi_req_data_o(req_data),
    .dmi_resp_valid_i(resp_valid),
    .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i(resp_data),
    .dmi_resp_resp_i(resp_resp)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a DR image, the holding registers, the sticky
  // error and the progress of at most one outstanding request.
  bit [40:0] m_dr;
  bit [6:0]  m_addr;
  bit [31:0] m_data;
  bit [1:0]  m_err;
  bit        m_req_out;
  bit        m_resp_out;
  bit        m_is_read;

  always @(posedge tck) begin
    bit        busy_now, cap, sh, up, in_flight, failed;
    bit [1:0]  new_err;
    bit [40:0] old_dr;
    if (rst) begin
      m_dr = '0; m_addr = '0; m_data = '0; m_err = '0;
      m_req_out = 0; m_resp_out = 0; m_is_read = 0;
    end else begin
      cap = capture && access;
      sh  = shift && access;
      up  = update && access;
      old_dr = m_dr;
      in_flight = m_req_out || m_resp_out;
      busy_now = in_flight && (cap || (up && m_err == 0));
      failed = m_resp_out && resp_valid && resp_resp != 0 && m_err == 0;
      if (dmi_reset)     new_err = 0;
      else if (busy_now) new_err = 3;
      else if (failed)   new_err = 2;
      else               new_err = m_err;
      if (cap)     m_dr = {m_addr, m_data, new_err};
      else if (sh) m_dr = (m_dr >> 1) | ({40'd0, tdi} << 40);
      if (up && m_err == 0 && !in_flight) begin
        m_addr = old_dr[40:34];
        m_data = old_dr[33:2];
        if (old_dr[1:0] == 1 || old_dr[1:0] == 2) begin
          m_req_out = 1;
          m_is_read = (old_dr[1:0] == 1);
        end
      end else if (m_req_out && req_ready) begin
        m_req_out = 0;
        m_resp_out = 1;
      end else if (m_resp_out && resp_valid) begin
        if (m_is_read) m_data = resp_data;
        m_resp_out = 0;
      end
      m_err = new_err;
    end
  end

  // Cycle-by-cycle comparison against the reference, away from the active edge
  always @(negedge tck) begin
    if (chk_en) begin
      chk("tdo", tdo, m_dr[0]);
      chk("dmi_error", err, m_err);
      chk("req_valid", req_valid, m_req_out);
      chk("resp_ready", resp_ready, m_resp_out);
      if (m_req_out) begin
        chk("req_op", req_op, m_is_read ? 2'd1 : 2'd2);
        chk("req_addr", req_addr, m_addr);
        chk("req_data", req_data, m_data);
      end
    end
  end

  task automatic tick();
    @(posedge tck);
    #2;
  endtask

  task automatic shift_in(input logic [40:0] v);
    for (int i = 0; i < 41; i++) begin
      shift = 1; tdi = v[i];
      tick();
    end
    shift = 0; tdi = 0;
  endtask

  task automatic pulse_update();
    update = 1; tick(); update = 0;
  endtask

  task automatic capture_read(output logic [40:0] got);
    capture = 1; tick(); capture = 0;
    for (int i = 0; i < 41; i++) begin
      got[i] = tdo;
      shift = 1; tdi = 0;
      tick();
    end
    shift = 0;
  endtask

  task automatic complete(input logic [31:0] d, input logic [1:0] r);
    req_ready = 1; tick(); req_ready = 0;
    resp_valid = 1; resp_data = d; resp_resp = r; tick();
    resp_valid = 0; resp_data = 0; resp_resp = 0;
  endtask

  initial begin
    logic [40:0] got;
    int r;
    access = 1;
    tick(); tick();
    rst = 0;
    chk_en = 1;
    chk("reset tdo", tdo, 1'b0);
    chk("reset err", err, 2'd0);
    chk("reset req_valid", req_valid, 1'b0);
    chk("reset resp_ready", resp_ready, 1'b0);
    chk("reset addr", req_addr, 7'd0);
    chk("reset data", req_data, 32'd0);

    // Write with stalled ready
    shift_in({7'h10, 32'hDEADBEEF, 2'd2});
    pulse_update();
    for (int i = 0; i < 3; i++) begin
      chk("wr valid", req_valid, 1'b1);
      chk("wr op", req_op, 2'd2);
      chk("wr addr", req_addr, 7'h10);
      chk("wr data", req_data, 32'hDEADBEEF);
      tick();
    end
    req_ready = 1; tick(); req_ready = 0;
    chk("wr resp_ready", resp_ready, 1'b1);
    chk("wr valid dropped", req_valid, 1'b0);
    resp_valid = 1; tick(); resp_valid = 0;
    chk("wr done resp_ready", resp_ready, 1'b0);
    chk("wr done err", err, 2'd0);

    // Read, then capture shows the returned data
    shift_in({7'h11, 32'h0, 2'd1});
    pulse_update();
    chk("rd op", req_op, 2'd1);
    chk("rd addr", req_addr, 7'h11);
    complete(32'h12345678, 2'd0);
    capture_read(got);
    chk("rd capture", got, {7'h11, 32'h12345678, 2'd0});

    // Busy
    shift_in({7'h05, 32'h0, 2'd1});
    pulse_update();
    capture = 1; tick(); capture = 0;
    chk("busy err", err, 2'd3);
    chk("busy captured op", tdo, 1'b1);
    shift_in({7'h06, 32'h0, 2'd2});
    pulse_update();
    chk("busy no new req op", req_op, 2'd1);
    chk("busy no new req addr", req_addr, 7'h05);
    dmi_reset = 1; tick(); dmi_reset = 0;
    chk("busy cleared", err, 2'd0);
    complete(32'h0, 2'd0);

    // Failure
    shift_in({7'h20, 32'hCAFE0000, 2'd2});
    pulse_update();
    complete(32'h0, 2'd2);
    chk("fail err", err, 2'd2);
    shift_in({7'h21, 32'h0, 2'd1});
    pulse_update();
    chk("fail blocks req", req_valid, 1'b0);
    dmi_reset = 1; tick(); dmi_reset = 0;
    chk("fail cleared", err, 2'd0);
    pulse_update();
    chk("after clear req", req_valid, 1'b1);
    chk("after clear addr", req_addr, 7'h21);
    complete(32'h0, 2'd0);

    // Nop and reserved ops load holding registers only
    shift_in({7'h33, 32'hA5A5A5A5, 2'd0});
    pulse_update();
    chk("nop no req", req_valid, 1'b0);
    capture_read(got);
    chk("nop capture", got, {7'h33, 32'hA5A5A5A5, 2'd0});
    shift_in({7'h44, 32'h01020304, 2'd3});
    pulse_update();
    chk("rsv no req", req_valid, 1'b0);
    capture_read(got);
    chk("rsv capture", got, {7'h44, 32'h01020304, 2'd0});

    // Reset in WaitRead
    shift_in({7'h7F, 32'h0, 2'd1});
    pulse_update();
    req_ready = 1; tick(); req_ready = 0;
    chk("pre-rst resp_ready", resp_ready, 1'b1);
    rst = 1; tick(); rst = 0;
    chk("rst req_valid", req_valid, 1'b0);
    chk("rst resp_ready", resp_ready, 1'b0);
    chk("rst err", err, 2'd0);
    capture_read(got);
    chk("rst capture", got, 41'd0);

    // Randomized traffic against the reference
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      access = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      capture = (r <= 1);
      shift = (r >= 2 && r <= 6);
      update = (r == 7);
      tdi = 1'($urandom_range(0, 1));
      dmi_reset = ($urandom_range(0, 14) == 0);
      req_ready = ($urandom_range(0, 2) == 0);
      resp_valid = ($urandom_range(0, 2) == 0);
      resp_data = $urandom;
      resp_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      tick();
    end
    rst = 0; capture = 0; shift = 0; update = 0; dmi_reset = 0;
    req_ready = 0; resp_valid = 0;
    tick(); tick();
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
